// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the multi-digit up/down counter.
package bcd_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;
  localparam logic [3:0]  BCD_MIN = 4'd0;

  // True when a nibble holds a legal decimal digit (0..9).
  function automatic logic bcd_digit_valid(input logic [BCD_W-1:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit with load, increment and decrement.
// Out-of-range load values (A..F) are loaded as 0.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  output logic [BCD_W-1:0] q,
  output logic             at_max,
  output logic             at_min
);

  logic [BCD_W-1:0] q_q;
  logic [BCD_W-1:0] q_d;

  // Next digit value: load beats inc beats dec; 9 rolls to 0 and 0 rolls to 9.
  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = bcd_digit_valid(ld_val) ? ld_val : BCD_MIN;
    end else if (inc) begin
      q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
    end else if (dec) begin
      q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
    end
  end

  // Digit register, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q      = q_q;
  assign at_max = (q_q == BCD_MAX);
  assign at_min = (q_q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter_n.sv
// Multi-digit BCD up/down counter with ripple carry/borrow, parallel load,
// wrap/saturate mode, terminal-count and wrap/load-error pulses.
module bcd_updown_counter_n
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          up_down,
  input  logic                          sat,
  input  logic                          load,
  input  logic [BCD_W*NUM_DIGITS-1:0]   load_val,
  output logic [BCD_W*NUM_DIGITS-1:0]   count,
  output logic                          tc,
  output logic                          wrap,
  output logic                          load_err
);

  logic [NUM_DIGITS-1:0] at_max;
  logic [NUM_DIGITS-1:0] at_min;
  logic [NUM_DIGITS-1:0] dig_inc;
  logic [NUM_DIGITS-1:0] dig_dec;
  logic [NUM_DIGITS-1:0] dig_bad;
  logic [NUM_DIGITS:0]   carry;
  logic [NUM_DIGITS:0]   borrow;
  logic                  all_max;
  logic                  all_min;
  logic                  step_up;
  logic                  step_dn;
  logic                  wrap_q, wrap_d;
  logic                  load_err_q, load_err_d;

  // carry[i]/borrow[i]: every digit below i sits at 9/0; the top entry covers the whole count.
  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;
  assign all_max   = carry[NUM_DIGITS];
  assign all_min   = borrow[NUM_DIGITS];

  // Saturation is applied by suppressing the whole step at the limit; without it the
  // digits roll over together, which is exactly the wrap behaviour.
  assign step_up = en & ~load &  up_down & ~(sat & all_max);
  assign step_dn = en & ~load & ~up_down & ~(sat & all_min);

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign carry[i+1]  = carry[i]  & at_max[i];
    assign borrow[i+1] = borrow[i] & at_min[i];
    assign dig_inc[i]  = step_up & carry[i];
    assign dig_dec[i]  = step_dn & borrow[i];
    assign dig_bad[i]  = ~bcd_digit_valid(load_val[BCD_W*i +: BCD_W]);

    bcd_digit u_digit (
      .clk    (clk),
      .reset  (reset),
      .inc    (dig_inc[i]),
      .dec    (dig_dec[i]),
      .ld     (load),
      .ld_val (load_val[BCD_W*i +: BCD_W]),
      .q      (count[BCD_W*i +: BCD_W]),
      .at_max (at_max[i]),
      .at_min (at_min[i])
    );
  end

  // Event pulses for the coming edge: wrap on an unsaturated limit crossing, error on a bad load.
  always_comb begin
    wrap_d     = en & ~load & ~sat & (up_down ? all_max : all_min);
    load_err_d = load & (|dig_bad);
  end

  // Flag registers, cleared asynchronously with the digits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign wrap     = wrap_q;
  assign load_err = load_err_q;
  assign tc       = up_down ? all_max : all_min;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
module tb_bcd_updown_counter_n;

  localparam int N    = 2;
  localparam int W    = 4 * N;
  localparam int MAXV = 99;

  typedef struct {
    logic         e, u, s, l;
    logic [W-1:0] lv;
    logic [W-1:0] ec;
    logic         ew, ee;
  } vec_t;

  typedef struct {
    logic [W-1:0] c;
    logic         w, e, t;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         en, up_down, sat, load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         tc, wrap, load_err;

  int   checks   = 0;
  int   failures = 0;
  int   mv       = 0;
  exp_t sb[$];
  vec_t tbl[24];

  bcd_updown_counter_n #(.NUM_DIGITS(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up_down  (up_down),
    .sat      (sat),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [W-1:0] b);
    int r  = 0;
    int pw = 1;
    for (int i = 0; i < N; i++) begin
      r  += int'(b[4*i +: 4]) * pw;
      pw *= 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model on a plain integer value.
  task automatic model_next(input logic e, u, s, l, input logic [W-1:0] lv, output exp_t x);
    x.w = 1'b0;
    x.e = 1'b0;
    if (l) begin
      int nv = 0;
      int pw = 1;
      for (int i = 0; i < N; i++) begin
        int d = int'(lv[4*i +: 4]);
        if (d > 9) begin
          d   = 0;
          x.e = 1'b1;
        end
        nv += d * pw;
        pw *= 10;
      end
      mv = nv;
    end else if (e) begin
      if (u) begin
        if (mv == MAXV) begin
          if (!s) begin mv = 0; x.w = 1'b1; end
        end else mv = mv + 1;
      end else begin
        if (mv == 0) begin
          if (!s) begin mv = MAXV; x.w = 1'b1; end
        end else mv = mv - 1;
      end
    end
    x.c = to_bcd(mv);
    x.t = u ? (mv == MAXV) : (mv == 0);
  endtask

  task automatic apply(input logic e, u, s, l, input logic [W-1:0] lv,
                       input exp_t x, input string tag);
    exp_t g;
    @(negedge clk);
    en = e; up_down = u; sat = s; load = l; load_val = lv;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      g = sb.pop_front();
      chk({tag, "_count"},    32'(count),    32'(g.c));
      chk({tag, "_wrap"},     32'(wrap),     32'(g.w));
      chk({tag, "_load_err"}, 32'(load_err), 32'(g.e));
      chk({tag, "_tc"},       32'(tc),       32'(g.t));
    end
  endtask

  task automatic step(input logic e, u, s, l, input logic [W-1:0] lv, input string tag);
    exp_t x;
    model_next(e, u, s, l, lv, x);
    apply(e, u, s, l, lv, x, tag);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 8'h10, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h09, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h99, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 8'h30, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h42, 8'h42, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h42, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hFA, 8'h00, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h99, 8'h99, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h99, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h98, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 8'h05, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h06, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h06, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h07, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h07, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h19, 8'h19, 1'b0, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h20, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h09, 8'h09, 1'b0, 1'b0};
    tbl[22] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0};
    tbl[23] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h09, 1'b0, 1'b0};

    reset = 1'b0; en = 1'b0; up_down = 1'b1; sat = 1'b0; load = 1'b0; load_val = '0;
    #1;
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_wrap",     32'(wrap),     32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    mv = 0;

    // Table-driven vectors.
    for (int i = 0; i < 24; i++) begin
      exp_t x;
      x.c = tbl[i].ec;
      x.w = tbl[i].ew;
      x.e = tbl[i].ee;
      x.t = tbl[i].u ? (tbl[i].ec == to_bcd(MAXV)) : (tbl[i].ec == '0);
      apply(tbl[i].e, tbl[i].u, tbl[i].s, tbl[i].l, tbl[i].lv, x, $sformatf("tbl%0d", i));
      mv = from_bcd(tbl[i].ec);
    end

    // Asynchronous reset between edges while holding 0x47.
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h47, "ld47");
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_wrap",  32'(wrap),  32'd0);
    // A load presented while reset is held must not complete.
    @(negedge clk);
    load = 1'b1; load_val = 8'h55;
    @(posedge clk);
    #1;
    chk("rst_hold_load", 32'(count), 32'd0);
    @(negedge clk);
    load = 1'b0; load_val = '0;
    reset = 1'b1;
    mv = 0;

    // 100 up-count edges from 0x00: decade carries and the 99->00 wrap.
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, $sformatf("up%0d", i));

    // Saturation at both limits and direction reversal at the top.
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h99, "sat_ld99");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, $sformatf("sat_up%0d", i));
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "rev_dn");
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "sat_ld00");
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, $sformatf("sat_dn%0d", i));
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "wrap_dn");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "hold_after_wrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
